// File: rtl/pad_input_conditioner.sv
// Controller input conditioning: button debounce with press/release pulses and hysteretic axis directions.
// Optional AUTO_REPEAT_EN macro adds per-button auto-repeat pulses while a button is held.
module pad_input_conditioner #(
    parameter int NUM_BUTTONS    = 12,
    parameter int NUM_AXES       = 4,
    parameter int STABLE_SAMPLES = 3,
    parameter int AXIS_ON        = 48,
    parameter int AXIS_OFF       = 32,
    parameter int REPEAT_DELAY   = 30,
    parameter int REPEAT_RATE    = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sample_valid,
    input  logic [NUM_BUTTONS-1:0]  buttons_raw,
    input  logic [8*NUM_AXES-1:0]   axes_raw,
    output logic [NUM_BUTTONS-1:0]  buttons,
    output logic [NUM_BUTTONS-1:0]  pressed,
    output logic [NUM_BUTTONS-1:0]  released,
    output logic [NUM_AXES-1:0]     dir_pos,
    output logic [NUM_AXES-1:0]     dir_neg,
    output logic [NUM_BUTTONS-1:0]  repeat_pulse,
    output logic                    update
);

    localparam int CW = $clog2(STABLE_SAMPLES) + 1;
    localparam logic signed [8:0] ON_S  = 9'(AXIS_ON);
    localparam logic signed [8:0] OFF_S = 9'(AXIS_OFF);

    if (STABLE_SAMPLES < 1 || AXIS_OFF < 1 || AXIS_OFF > AXIS_ON || AXIS_ON > 127
        || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
        $error("pad_input_conditioner: illegal parameter set");
    end

    logic [NUM_BUTTONS-1:0]         stable_q, stable_d;
    logic [NUM_BUTTONS-1:0]         pressed_q, pressed_d;
    logic [NUM_BUTTONS-1:0]         released_q, released_d;
    logic [NUM_BUTTONS-1:0][CW-1:0] cnt_q, cnt_d;
    logic [NUM_AXES-1:0]            pos_q, pos_d;
    logic [NUM_AXES-1:0]            neg_q, neg_d;
    logic                           update_q;
    logic signed [8:0]              off;

    always_comb begin
        stable_d   = stable_q;
        cnt_d      = cnt_q;
        pressed_d  = '0;
        released_d = '0;
        pos_d      = pos_q;
        neg_d      = neg_q;
        off        = '0;
        if (sample_valid) begin
            for (int b = 0; b < NUM_BUTTONS; b++) begin
                if (buttons_raw[b] == stable_q[b]) begin
                    cnt_d[b] = '0;
                end else if (cnt_q[b] + CW'(1) == CW'(STABLE_SAMPLES)) begin
                    stable_d[b]   = buttons_raw[b];
                    cnt_d[b]      = '0;
                    pressed_d[b]  = buttons_raw[b];
                    released_d[b] = ~buttons_raw[b];
                end else begin
                    cnt_d[b] = cnt_q[b] + CW'(1);
                end
            end
            // Set and clear thresholds are disjoint, so pos and neg cannot both be set.
            for (int a = 0; a < NUM_AXES; a++) begin
                off = $signed({1'b0, axes_raw[8*a +: 8]}) - 9'sd128;
                if (off >= ON_S) begin
                    pos_d[a] = 1'b1;
                end else if (off < OFF_S) begin
                    pos_d[a] = 1'b0;
                end
                if (off <= -ON_S) begin
                    neg_d[a] = 1'b1;
                end else if (off > -OFF_S) begin
                    neg_d[a] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_q   <= '0;
            cnt_q      <= '0;
            pressed_q  <= '0;
            released_q <= '0;
            pos_q      <= '0;
            neg_q      <= '0;
            update_q   <= 1'b0;
        end else begin
            stable_q   <= stable_d;
            cnt_q      <= cnt_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
            pos_q      <= pos_d;
            neg_q      <= neg_d;
            update_q   <= sample_valid;
        end
    end

    assign buttons  = stable_q;
    assign pressed  = pressed_q;
    assign released = released_q;
    assign dir_pos  = pos_q;
    assign dir_neg  = neg_q;
    assign update   = update_q;

`ifdef AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    logic [NUM_BUTTONS-1:0][RW-1:0] rcnt_q, rcnt_d;
    logic [NUM_BUTTONS-1:0]         armed_q, armed_d;
    logic [NUM_BUTTONS-1:0]         rep_q, rep_d;
    logic [RW-1:0]                  target;

    // Counter restarts at each pulse and never passes its target, so it cannot wrap.
    always_comb begin
        rcnt_d  = rcnt_q;
        armed_d = armed_q;
        rep_d   = '0;
        target  = '0;
        if (sample_valid) begin
            for (int b = 0; b < NUM_BUTTONS; b++) begin
                target = armed_q[b] ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);
                if (!stable_d[b] || pressed_d[b]) begin
                    rcnt_d[b]  = '0;
                    armed_d[b] = 1'b0;
                end else if (rcnt_q[b] + RW'(1) == target) begin
                    rcnt_d[b]  = '0;
                    armed_d[b] = 1'b1;
                    rep_d[b]   = 1'b1;
                end else begin
                    rcnt_d[b] = rcnt_q[b] + RW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rcnt_q  <= '0;
            armed_q <= '0;
            rep_q   <= '0;
        end else begin
            rcnt_q  <= rcnt_d;
            armed_q <= armed_d;
            rep_q   <= rep_d;
        end
    end

    assign repeat_pulse = rep_q;
`else
    assign repeat_pulse = '0;
`endif

endmodule

// File: tb/tb_pad_input_conditioner.sv
// Directed-vector scoreboard bench for pad_input_conditioner (default parameters).
// Expected results are queued per sample and checked by a monitor on each update.
module tb_pad_input_conditioner;

`ifdef AUTO_REPEAT_EN
    localparam bit ARE = 1'b1;
`else
    localparam bit ARE = 1'b0;
`endif
    localparam logic [31:0] CTR = {4{8'd128}};

    typedef struct {
        logic [11:0] b, p, r, rp;
        logic [3:0]  dp, dn;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_valid;
    logic [11:0] buttons_raw;
    logic [31:0] axes_raw;
    logic [11:0] buttons, pressed, released, repeat_pulse;
    logic [3:0]  dir_pos, dir_neg;
    logic        update;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sbq[$];

    pad_input_conditioner dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid),
        .buttons_raw(buttons_raw), .axes_raw(axes_raw),
        .buttons(buttons), .pressed(pressed), .released(released),
        .dir_pos(dir_pos), .dir_neg(dir_neg),
        .repeat_pulse(repeat_pulse), .update(update)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic exp_t E(logic [11:0] b, p, r, rp, logic [3:0] dp, dn);
        exp_t e;
        e.b = b; e.p = p; e.r = r; e.rp = rp; e.dp = dp; e.dn = dn;
        return e;
    endfunction

    function automatic logic [31:0] ax(logic [7:0] a3, a2, a1, a0);
        return {a3, a2, a1, a0};
    endfunction

    task automatic smp(input logic [11:0] raw, input logic [31:0] a, input exp_t e);
        @(negedge clk);
        sample_valid = 1'b1;
        buttons_raw  = raw;
        axes_raw     = a;
        sbq.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic chk_held(input string n, input logic [11:0] b, input logic [3:0] dp, dn);
        chk({n, " buttons"},  32'(buttons),  32'(b));
        chk({n, " pressed"},  32'(pressed),  32'd0);
        chk({n, " released"}, 32'(released), 32'd0);
        chk({n, " repeat"},   32'(repeat_pulse), 32'd0);
        chk({n, " dir_pos"},  32'(dir_pos),  32'(dp));
        chk({n, " dir_neg"},  32'(dir_neg),  32'(dn));
        chk({n, " update"},   32'(update),   32'd0);
    endtask

    // Monitor: pops one expectation per update, otherwise pulses must be idle.
    always @(negedge clk) begin
        if (!reset) begin
            if (update) begin
                if (sbq.size() == 0) begin
                    chk("unexpected update", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("buttons",  32'(buttons),      32'(e.b));
                    chk("pressed",  32'(pressed),      32'(e.p));
                    chk("released", 32'(released),     32'(e.r));
                    chk("repeat",   32'(repeat_pulse), 32'(e.rp));
                    chk("dir_pos",  32'(dir_pos),      32'(e.dp));
                    chk("dir_neg",  32'(dir_neg),      32'(e.dn));
                end
            end else begin
                chk("idle pulses", 32'(pressed | released | repeat_pulse), 32'd0);
            end
        end
    end

    initial begin
        logic [11:0] rp;
        reset        = 1'b1;
        sample_valid = 1'b0;
        buttons_raw  = 12'hFFF;
        axes_raw     = CTR;
        repeat (3) @(negedge clk);
        chk_held("reset", 12'h000, 4'h0, 4'h0);
        reset = 1'b0;

        // Buttons held through reset: accepted on the third sample only.
        smp(12'hFFF, CTR, E(12'h000, 12'h000, 12'h000, 12'h0, 4'h0, 4'h0));
        smp(12'hFFF, CTR, E(12'h000, 12'h000, 12'h000, 12'h0, 4'h0, 4'h0));
        smp(12'hFFF, CTR, E(12'hFFF, 12'hFFF, 12'h000, 12'h0, 4'h0, 4'h0));
        smp(12'hFFF, CTR, E(12'hFFF, 12'h000, 12'h000, 12'h0, 4'h0, 4'h0));
        smp(12'h000, CTR, E(12'hFFF, 12'h000, 12'h000, 12'h0, 4'h0, 4'h0));
        smp(12'h000, CTR, E(12'hFFF, 12'h000, 12'h000, 12'h0, 4'h0, 4'h0));
        smp(12'h000, CTR, E(12'h000, 12'h000, 12'hFFF, 12'h0, 4'h0, 4'h0));

        // Bouncing button0 alongside axis0/axis1 hysteresis sequences.
        smp(12'h001, ax(128, 128, 80, 128), E(12'h000, 12'h000, 12'h000, 12'h0, 4'h0, 4'h2));
        smp(12'h000, ax(128, 128, 0, 175),  E(12'h000, 12'h000, 12'h000, 12'h0, 4'h0, 4'h2));
        smp(12'h001, ax(128, 128, 97, 176), E(12'h000, 12'h000, 12'h000, 12'h0, 4'h1, 4'h0));
        smp(12'h001, ax(128, 128, 96, 161), E(12'h000, 12'h000, 12'h000, 12'h0, 4'h1, 4'h0));
        smp(12'h001, ax(128, 128, 96, 159), E(12'h001, 12'h001, 12'h000, 12'h0, 4'h0, 4'h0));
        smp(12'h000, ax(0, 255, 128, 128),  E(12'h001, 12'h000, 12'h000, 12'h0, 4'h4, 4'h8));
        smp(12'h000, ax(0, 255, 128, 128),  E(12'h001, 12'h000, 12'h000, 12'h0, 4'h4, 4'h8));
        idle();

        // Raw activity without sample_valid must be ignored.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            buttons_raw = 12'($urandom);
            axes_raw    = $urandom;
            chk_held("hold", 12'h001, 4'h4, 4'h8);
        end
        smp(12'h000, CTR, E(12'h000, 12'h000, 12'h001, 12'h0, 4'h0, 4'h0));

        // Reset in the middle of a debounce.
        smp(12'h002, ax(128, 128, 128, 200), E(12'h000, 12'h000, 12'h000, 12'h0, 4'h1, 4'h0));
        smp(12'h002, ax(128, 128, 128, 200), E(12'h000, 12'h000, 12'h000, 12'h0, 4'h1, 4'h0));
        idle();
        #2 reset = 1'b1;
        #1 chk_held("mid reset", 12'h000, 4'h0, 4'h0);
        @(negedge clk);
        reset = 1'b0;
        smp(12'h002, ax(128, 128, 128, 200), E(12'h000, 12'h000, 12'h000, 12'h0, 4'h1, 4'h0));
        smp(12'h002, ax(128, 128, 128, 200), E(12'h000, 12'h000, 12'h000, 12'h0, 4'h1, 4'h0));
        smp(12'h002, ax(128, 128, 128, 200), E(12'h002, 12'h002, 12'h000, 12'h0, 4'h1, 4'h0));

        // Button1 released while button3 pressed and then held for 50 samples.
        smp(12'h008, CTR, E(12'h002, 12'h000, 12'h000, 12'h0, 4'h0, 4'h0));
        smp(12'h008, CTR, E(12'h002, 12'h000, 12'h000, 12'h0, 4'h0, 4'h0));
        smp(12'h008, CTR, E(12'h008, 12'h008, 12'h002, 12'h0, 4'h0, 4'h0));
        for (int k = 1; k <= 50; k++) begin
            rp = (ARE && (k == 30 || k == 36 || k == 42 || k == 48)) ? 12'h008 : 12'h000;
            smp(12'h008, CTR, E(12'h008, 12'h000, 12'h000, rp, 4'h0, 4'h0));
        end
        smp(12'h000, CTR, E(12'h008, 12'h000, 12'h000, 12'h0, 4'h0, 4'h0));
        smp(12'h000, CTR, E(12'h008, 12'h000, 12'h000, 12'h0, 4'h0, 4'h0));
        smp(12'h000, CTR, E(12'h000, 12'h000, 12'h008, 12'h0, 4'h0, 4'h0));
        idle();
        repeat (3) @(negedge clk);
        chk("scoreboard drained", 32'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
